// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } state_e;

  localparam int WORD_W         = 32;
  localparam int STARVE_W       = 3;
  localparam int WAIT_W         = 4;
  localparam int STARVE_MAX_DEF = 4;
  localparam int TIMEOUT_DEF    = 15;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter; master is the arbiter's view.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = WORD_W
);
  logic              if_req;
  logic [DATA_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [DATA_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              err;

  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, err
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, err
  );
endinterface

// File: rtl/arb_prio.sv
// Grant selection between fetch and data requesters with a starvation guard for fetch.
module arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic idle,
  input  logic if_req,
  input  logic d_req,
  output logic if_gnt,
  output logic d_gnt
);
  logic [STARVE_W-1:0] starve_cnt_q;
  logic                fetch_wins;

  // Data normally wins; a fetch that has watched STARVE_MAX data grants takes the next slot.
  assign fetch_wins = if_req && (starve_cnt_q == STARVE_W'(STARVE_MAX));
  assign d_gnt      = reset && idle && d_req && !fetch_wins;
  assign if_gnt     = reset && idle && if_req && !d_gnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt_q <= '0;
    end else if (if_gnt) begin
      starve_cnt_q <= '0;
    end else if (d_gnt && if_req && (starve_cnt_q != '1)) begin
      starve_cnt_q <= starve_cnt_q + STARVE_W'(1);
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: grants fetch or data access, holds the bus until ready or timeout.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input logic           clock,
  input logic           reset,
  mem_arbiter_if.master bus
);
  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q;
  logic                if_gnt, d_gnt, idle, busy, done_ok, done_to;
  logic                mem_en_q, mem_we_q, if_valid_q, d_valid_q, err_q;
  logic [WORD_W-1:0]   mem_addr_q, mem_wdata_q, if_rdata_q, d_rdata_q;

  assign idle    = (state_q == IDLE);
  assign busy    = !idle;
  assign done_ok = busy && bus.mem_ready;
  assign done_to = busy && !bus.mem_ready && (wait_cnt_q == WAIT_W'(TIMEOUT - 1));

  arb_prio #(
    .STARVE_MAX(STARVE_MAX)
  ) u_arb_prio (
    .clock  (clock),
    .reset  (reset),
    .idle   (idle),
    .if_req (bus.if_req),
    .d_req  (bus.d_req),
    .if_gnt (if_gnt),
    .d_gnt  (d_gnt)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (if_gnt)     state_d = BUSY_IF;
        else if (d_gnt) state_d = BUSY_D;
      end
      BUSY_IF, BUSY_D: begin
        if (done_ok || done_to) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt_q  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      err_q      <= 1'b0;
      if (if_gnt || d_gnt) begin
        // Request fields are captured here so the requester is free to move on next cycle.
        wait_cnt_q <= '0;
        mem_en_q   <= 1'b1;
        mem_we_q   <= d_gnt && bus.d_we;
        mem_addr_q <= if_gnt ? bus.if_addr : bus.d_addr;
        if (d_gnt && bus.d_we) mem_wdata_q <= bus.d_wdata;
      end else if (busy) begin
        if (wait_cnt_q != '1) wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
        if (done_ok || done_to) begin
          mem_en_q   <= 1'b0;
          mem_we_q   <= 1'b0;
          if_valid_q <= (state_q == BUSY_IF);
          d_valid_q  <= (state_q == BUSY_D);
          err_q      <= done_to;
          if (done_ok && (state_q == BUSY_IF))              if_rdata_q <= bus.mem_rdata;
          if (done_ok && (state_q == BUSY_D) && !mem_we_q)  d_rdata_q  <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.err       = err_q;
endmodule
